// File: rtl/axil_pkg.sv
// Shared types and the address decoder for the AXI4-Lite slave memory.
package axil_pkg;

  localparam int unsigned ERR_W = 16;
  localparam int unsigned LAT_W = 3;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_WAIT = 2'b01,
    R_RESP = 2'b10
  } rd_state_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] idx;
  } dec_t;

  // Word index relative to base; addresses below base or past depth miss.
  function automatic dec_t addr_decode(input logic [63:0] addr, input logic [63:0] base,
                                       input int unsigned depth, input int unsigned bytes);
    logic [63:0] off;
    logic [63:0] idx_w;
    dec_t        d;
    off   = addr - base;
    idx_w = (bytes == 8) ? (off >> 3) : (off >> 2);
    d.hit = (addr >= base) && (idx_w < 64'(depth));
    d.idx = 32'(idx_w);
    return d;
  endfunction

endpackage

// File: rtl/axil_slave_mem_if.sv
// AXI4-Lite bus bundle between a master and the slave memory.
interface axil_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_slave_mem_rd.sv
// Read channel: captures data at the AR handshake and presents it RD_LATENCY cycles later.
module axil_slave_mem_rd
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  arvalid_i,
  input  logic                  rready_i,
  input  logic                  ar_hit_i,
  input  logic [DATA_WIDTH-1:0] ar_data_i,
  output logic                  arready_c,
  output logic                  rvalid_c,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o
);

  rd_state_t             state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;

  assign arready_c = en_i && (state_q == R_IDLE);
  assign rvalid_c  = (state_q == R_RESP);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      lat_q   <= '0;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (state_q)
      R_IDLE: begin
        if (arvalid_i && arready_c) begin
          rdata_d = ar_hit_i ? ar_data_i : '0;
          rresp_d = ar_hit_i ? OKAY : DECERR;
          lat_d   = LAT_W'(RD_LATENCY - 1);
          state_d = (RD_LATENCY == 1) ? R_RESP : R_WAIT;
        end
      end
      R_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_d == '0) state_d = R_RESP;
      end
      R_RESP: begin
        if (rready_i) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: rtl/axil_slave_mem.sv
// AXI4-Lite slave memory: byte-strobed word storage, decoupled AW/W holds,
// configurable read latency, DECERR outside the window and a saturating error count.
module axil_slave_mem
  import axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_1000),
  parameter int unsigned           RD_LATENCY = 1
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  axil_slave_mem_if.slave  bus,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rdy_q;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [BYTES-1:0]      w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic [ERR_W:0]        err_sum;

  logic aw_hs, w_hs, ar_hs, commit;
  dec_t w_dec, r_dec;

  // Ready outputs stay low until the first clock after reset release.
  assign bus.AWREADY = rdy_q && !aw_held_q;
  assign bus.WREADY  = rdy_q && !w_held_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign err_cnt     = err_q;

  assign aw_hs = bus.AWVALID && bus.AWREADY;
  assign w_hs  = bus.WVALID && bus.WREADY;
  assign ar_hs = bus.ARVALID && bus.ARREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      err_q     <= '0;
    end else begin
      rdy_q     <= 1'b1;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      err_q     <= err_d;
    end
  end

  // Write path: a handshake in the current cycle counts as held, so commit can be immediate.
  always_comb begin
    aw_addr_d = aw_held_q ? aw_addr_q : bus.AWADDR;
    w_data_d  = w_held_q ? w_data_q : bus.WDATA;
    w_strb_d  = w_held_q ? w_strb_q : bus.WSTRB;
    commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs) && (!bvalid_q || bus.BREADY);
    aw_held_d = (aw_held_q || aw_hs) && !commit;
    w_held_d  = (w_held_q || w_hs) && !commit;
    w_dec     = addr_decode(64'(aw_addr_d), 64'(BASE_ADDR), DEPTH, BYTES);
    bvalid_d  = bvalid_q && !bus.BREADY;
    bresp_d   = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = w_dec.hit ? OKAY : DECERR;
    end
  end

  always_ff @(posedge ACLK) begin
    if (commit && w_dec.hit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (w_strb_d[i]) mem_q[IDX_W'(w_dec.idx)][8*i +: 8] <= w_data_d[8*i +: 8];
      end
    end
  end

  assign r_dec = addr_decode(64'(bus.ARADDR), 64'(BASE_ADDR), DEPTH, BYTES);

  // One count per DECERR; a B and an R error on the same edge add two.
  always_comb begin
    err_sum = (ERR_W + 1)'(err_q) + (ERR_W + 1)'(commit && !w_dec.hit)
            + (ERR_W + 1)'(ar_hs && !r_dec.hit);
    err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
  end

  axil_slave_mem_rd #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .en_i      (rdy_q),
    .arvalid_i (bus.ARVALID),
    .rready_i  (bus.RREADY),
    .ar_hit_i  (r_dec.hit),
    .ar_data_i (mem_q[IDX_W'(r_dec.idx)]),
    .arready_c (bus.ARREADY),
    .rvalid_c  (bus.RVALID),
    .rdata_o   (bus.RDATA),
    .rresp_o   (bus.RRESP)
  );

endmodule

// File: tb/tb_axil_slave_mem.sv
// Self-checking bench for axil_slave_mem: vector table plus hand-written latency,
// backpressure, collision-of-errors and reset corner cases.
module tb_axil_slave_mem;
  import axil_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [15:0] err;
  } vec_t;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [15:0] err_cnt;
  int          checks = 0;
  int          errors = 0;

  logic [1:0]  b_q [$];
  r_exp_t      r_q [$];
  logic [1:0]  exp_b;
  r_exp_t      exp_r;
  vec_t        vt [8];

  always #5 ACLK = ~ACLK;

  axil_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_slave_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (256),
    .BASE_ADDR  (32'h0000_1000),
    .RD_LATENCY (LAT)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask

  // Scoreboard: pop an expected response on every B/R handshake.
  always @(negedge ACLK) begin
    if (ARESETN === 1'b1 && bus.BVALID && bus.BREADY) begin
      if (b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: BRESP %0h with none expected", bus.BRESP);
      end else begin
        exp_b = b_q.pop_front();
        check("bresp", 64'(bus.BRESP), 64'(exp_b));
      end
    end
    if (ARESETN === 1'b1 && bus.RVALID && bus.RREADY) begin
      if (r_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected: RDATA %0h RRESP %0h with none expected", bus.RDATA, bus.RRESP);
      end else begin
        exp_r = r_q.pop_front();
        check("rdata", 64'(bus.RDATA), 64'(exp_r.data));
        check("rresp", 64'(bus.RRESP), 64'(exp_r.resp));
      end
    end
  end

  task automatic drive_aw(input logic [31:0] a);
    int n = 0;
    bus.AWADDR  = a;
    bus.AWVALID = 1'b1;
    @(negedge ACLK);
    while (!bus.AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.AWREADY) timeout("aw_ready");
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.WDATA  = d;
    bus.WSTRB  = s;
    bus.WVALID = 1'b1;
    @(negedge ACLK);
    while (!bus.WREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.WREADY) timeout("w_ready");
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
  endtask

  task automatic drive_ar(input logic [31:0] a);
    int n = 0;
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    @(negedge ACLK);
    while (!bus.ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!bus.ARREADY) timeout("ar_ready");
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic wait_b_empty();
    int n = 0;
    while (b_q.size() != 0 && n < 40) begin @(negedge ACLK); n++; end
    if (b_q.size() != 0) timeout("b_resp");
    @(posedge ACLK); #1;
  endtask

  task automatic wait_r_empty();
    int n = 0;
    while (r_q.size() != 0 && n < 40) begin @(negedge ACLK); n++; end
    if (r_q.size() != 0) timeout("r_resp");
    @(posedge ACLK); #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp);
    b_q.push_back(resp);
    fork
      drive_aw(a);
      drive_w(d, s);
    join
    wait_b_empty();
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    r_exp_t e;
    e.data = d;
    e.resp = resp;
    r_q.push_back(e);
    drive_ar(a);
    wait_r_empty();
  endtask

  initial begin
    vt[0] = '{32'h0000_1000, 32'hA5A5_A5A5, 4'hF, OKAY,   32'hA5A5_A5A5, OKAY,   16'd0};
    vt[1] = '{32'h0000_1003, 32'h5A5A_5AFF, 4'h1, OKAY,   32'hA5A5_A5FF, OKAY,   16'd0};
    vt[2] = '{32'h0000_1001, 32'hFFFF_FFFF, 4'h0, OKAY,   32'hA5A5_A5FF, OKAY,   16'd0};
    vt[3] = '{32'h0000_13FC, 32'h1234_5678, 4'hF, OKAY,   32'h1234_5678, OKAY,   16'd0};
    vt[4] = '{32'h0000_13FE, 32'hAABB_CCDD, 4'hC, OKAY,   32'hAABB_5678, OKAY,   16'd0};
    vt[5] = '{32'h0000_1400, 32'hFFFF_FFFF, 4'hF, DECERR, 32'h0000_0000, DECERR, 16'd2};
    vt[6] = '{32'h0000_0FFC, 32'h0000_0001, 4'hF, DECERR, 32'h0000_0000, DECERR, 16'd4};
    vt[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 4'hF, DECERR, 32'h0000_0000, DECERR, 16'd6};

    ARESETN     = 1'b0;
    bus.AWADDR  = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b1;
    bus.ARADDR  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b1;

    // Reset state and release
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'(3'b000));
    check("rst_valids", 64'({bus.BVALID, bus.RVALID}), 64'(2'b00));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
    check("rst_rdata", 64'({bus.RDATA, bus.RRESP, bus.BRESP}), 64'(0));
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("idle_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'(3'b111));
    check("idle_valids", 64'({bus.BVALID, bus.RVALID}), 64'(2'b00));
    @(posedge ACLK); #1;

    // Vector table: write, read back, running error count
    for (int i = 0; i < 8; i++) begin
      axi_write(vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].bresp);
      axi_read(vt[i].addr, vt[i].rdata, vt[i].rresp);
      check($sformatf("err_cnt_vec%0d", i), 64'(err_cnt), 64'(vt[i].err));
    end
    // Out-of-window write must not have aliased onto word 0
    axi_read(32'h0000_1000, 32'hA5A5_A5FF, OKAY);

    // AW+W same cycle: BVALID one cycle later; read shows up LAT cycles after AR
    b_q.push_back(OKAY);
    bus.AWADDR = 32'h0000_1004; bus.AWVALID = 1'b1;
    bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge ACLK);
    check("aw_w_ready", 64'({bus.AWREADY, bus.WREADY}), 64'(2'b11));
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    @(negedge ACLK);
    check("b_latency", 64'(bus.BVALID), 64'(1));
    @(posedge ACLK); #1;
    r_q.push_back('{32'hDEAD_BEEF, OKAY});
    bus.ARADDR = 32'h0000_1004; bus.ARVALID = 1'b1;
    @(negedge ACLK);
    check("ar_ready", 64'(bus.ARREADY), 64'(1));
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge ACLK);
      check($sformatf("r_latency_c%0d", k), 64'(bus.RVALID), 64'(k == int'(LAT)));
    end
    @(posedge ACLK); #1;

    // W ahead of AW with partial strobes
    b_q.push_back(OKAY);
    drive_w(32'h1122_3344, 4'b0101);
    @(negedge ACLK);
    check("w_held_c1", 64'({bus.WREADY, bus.BVALID}), 64'(2'b00));
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("w_held_c2", 64'({bus.WREADY, bus.BVALID}), 64'(2'b00));
    @(posedge ACLK); #1;
    drive_aw(32'h0000_1004);
    wait_b_empty();
    axi_read(32'h0000_1004, 32'hDE22_BE44, OKAY);

    // B backpressure: second write waits in the holds, then replaces the response
    bus.BREADY = 1'b0;
    b_q.push_back(OKAY);
    b_q.push_back(DECERR);
    fork
      drive_aw(32'h0000_1008);
      drive_w(32'hCAFE_0001, 4'hF);
    join
    fork
      drive_aw(32'h0000_1400);
      drive_w(32'hFFFF_FFFF, 4'hF);
    join
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check($sformatf("b_stall%0d", k),
            64'({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}), 64'(5'b1_00_00));
    end
    @(posedge ACLK); #1;
    bus.BREADY = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
    @(negedge ACLK);
    check("b_second", 64'({bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}), 64'(5'b1_11_11));
    @(posedge ACLK); #1;
    bus.BREADY = 1'b1;
    wait_b_empty();
    check("err_cnt_bp", 64'(err_cnt), 64'(7));
    axi_read(32'h0000_1008, 32'hCAFE_0001, OKAY);

    // B and R DECERR on the same edge count twice
    b_q.push_back(DECERR);
    r_q.push_back('{32'h0, DECERR});
    bus.AWADDR = 32'h0000_1400; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h5555_AAAA; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 32'h0000_0FFC; bus.ARVALID = 1'b1;
    @(negedge ACLK);
    check("dual_ready", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'(3'b111));
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    @(negedge ACLK);
    check("err_cnt_dual", 64'(err_cnt), 64'(9));
    wait_b_empty();
    wait_r_empty();

    // Reset while the read is waiting out its latency
    drive_ar(32'h0000_1004);
    @(negedge ACLK);
    check("rwait_rvalid", 64'(bus.RVALID), 64'(0));
    ARESETN = 1'b0;
    #1;
    check("mid_rst_outs", 64'({bus.RVALID, bus.ARREADY, bus.AWREADY}), 64'(0));
    check("mid_rst_err", 64'(err_cnt), 64'(0));
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      check($sformatf("post_rst_rvalid%0d", k), 64'(bus.RVALID), 64'(0));
    end
    check("post_rst_arready", 64'(bus.ARREADY), 64'(1));
    @(posedge ACLK); #1;
    axi_read(32'h0000_1004, 32'hDE22_BE44, OKAY);
    check("post_rst_err", 64'(err_cnt), 64'(0));

    check("b_queue_empty", 64'(b_q.size()), 64'(0));
    check("r_queue_empty", 64'(r_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_slave_mem.md
Name: axil_slave_mem

Overview:
Parametrised AXI4-Lite slave memory: a synthesizable responder for the DMA controller's slave port in place of a passive bus bundle. It provides word-addressed storage with byte-strobe writes, decoupled AW/W acceptance and configurable read latency. Out-of-window accesses return DECERR, and a saturating error counter is exposed. It sits on the DMA interconnect as the target for DMA transfers and as the UVM DUT-side memory.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width; legal values are 32 or 64.
- DEPTH, 256, number of DATA_WIDTH words; must be a power of 2.
- BASE_ADDR, 32'h0000_1000, byte address of word 0.
- RD_LATENCY, 1, cycles from AR handshake to RVALID; legal range 1..8.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte strobes.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- err_cnt  out  16  saturating count of DECERR responses (B and R).

Behaviour:
- Reset (ARESETN low, asynchronous):
  - BVALID, RVALID = 0; BRESP, RRESP = 2'b00; RDATA = 0; err_cnt = 0.
  - AW/W holding registers and the read FSM clear; AWREADY, WREADY, ARREADY = 0 while in reset.
  - Memory array is not reset.
  - A reset mid-transaction discards held AW/W (no write commits) and any in-flight read.
- Decode:
  - idx = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
  - In range iff addr >= BASE_ADDR and idx < DEPTH; otherwise the response is DECERR (2'b11).
- Write path:
  - AW and W each have a 1-entry holding register: AWREADY = !aw_held, WREADY = !w_held. AW and W may arrive in either order or in the same cycle.
  - Commit at the edge where aw_held & w_held & (!BVALID | BREADY):
    - In range: byte lane i is written iff WSTRB[i]; WSTRB = 0 writes nothing and returns OKAY.
    - Out of range: no write; DECERR.
    - Both holds clear; BVALID = 1 and BRESP is set from the next cycle.
  - BVALID and BRESP are held stable until BREADY. A new commit in the same cycle as a B handshake keeps BVALID high with the new BRESP.
  - Latency: BVALID is high 1 cycle after the cycle of the later AW/W handshake, given B is idle.
- Read path, FSM R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: ARREADY = 1. On AR handshake, capture mem[idx] (or 0 with DECERR if out of range) and load lat_cnt = RD_LATENCY-1. Go to R_RESP if RD_LATENCY == 1, else R_WAIT.
  - R_WAIT: decrement lat_cnt; at 0 go to R_RESP.
  - R_RESP: RVALID = 1 with RDATA/RRESP stable until RREADY; on handshake go to R_IDLE. ARREADY is 0 outside R_IDLE.
  - Latency: RVALID is high RD_LATENCY cycles after the AR handshake cycle.
- Read/write collision:
  - Data is captured at the AR handshake edge.
  - A write committing on the same edge is not visible; the read returns the old data.
- err_cnt:
  - Increments by 1 per DECERR issued (on commit/capture).
  - Increments by 2 if a B and an R DECERR occur on the same edge.
  - Saturates at 16'hFFFF.
- The read and write paths are fully independent; no ordering between them.

Decomposition:
- Package axil_pkg holds:
  - the resp_t enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11;
  - the rd_state_t enum;
  - function addr_decode(addr, base, depth, bytes) returning {hit, idx}.
- One sub-module, axil_slave_mem_rd: read FSM plus latency counter.
- The write path and memory array stay in the top module.

Test Plan:
- Reset then idle: after release, AWREADY = WREADY = ARREADY = 1; BVALID = RVALID = 0; err_cnt = 0.
- Write then read: AW 0x1004 + W 0xDEADBEEF, WSTRB 4'hF in the same cycle -> BVALID next cycle, BRESP OKAY. AR 0x1004 with RD_LATENCY = 3 -> RVALID 3 cycles later, RDATA 0xDEADBEEF, RRESP OKAY.
- Partial strobe, W before AW: W 0x11223344 with WSTRB 4'b0101, then AW 0x1004 two cycles later -> WREADY = 0 while held. Readback of 0x1004 = 0xDE22BE44.
- B backpressure: BREADY = 0 for 5 cycles -> BVALID and BRESP stable. A second AW/W is accepted into the holds but not committed until the B handshake; then BVALID stays high for the second response.
- Out of range: AW 0x1400 W 0xFFFFFFFF -> BRESP DECERR, no memory change. AR 0x0FFC -> RDATA 0, RRESP DECERR; err_cnt = 2.
- Reset mid-read: assert ARESETN low during R_WAIT -> RVALID stays 0. After release, ARREADY = 1 and a new read returns correct data.
